alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Registered command front-end for the 4-bit combinational arithmetic unit (ADD/SUB/MUL/DIV). It accepts operations over a valid/ready command channel and holds the operands and opcode stable on the unit's inputs for a configurable settle time. It then captures the unit's outputs, sanitises undefined results (carry on MUL/DIV, divide-by-zero) and presents them on a valid/ready response channel. It sits directly upstream of the arithmetic unit and is its only driver.

## Interface
- SETTLE_CYCLES, 1, clock edges between operand launch and result capture; legal range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a, cmd_b  in  4 each  operands A and B.
- cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- alu_a, alu_b  out  4 each  registered operands driven to the arithmetic unit.
- alu_control  out  2  registered opcode driven to the arithmetic unit.
- alu_op  in  4  arithmetic unit result.
- alu_c_out  in  1  arithmetic unit carry/borrow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  4  captured result.
- rsp_carry  out  1  carry (ADD) / carry-out of A+~B+1 (SUB); 0 for MUL and DIV.
- rsp_err  out  1  1 only for DIV with B = 0.
- stat_cmds, stat_errs  out  8 each  present only with ALU_SEQ_STATS_EN.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on cmd_valid && cmd_ready.
  - ISSUE → RESP when the settle counter expires.
  - RESP → IDLE on rsp_valid && rsp_ready.
- cmd_ready = 1 only in IDLE; combinational from state, never from cmd_valid.
- Accept edge: cmd_a, cmd_b and cmd_op are loaded into alu_a, alu_b and alu_control. The settle counter loads SETTLE_CYCLES-1.
- ISSUE: alu_* are held constant. The counter decrements each edge; at count 0 the next edge captures results and enters RESP.
- Capture rules:
  - ADD/SUB: rsp_result = alu_op; rsp_carry = alu_c_out.
  - MUL: rsp_result = alu_op; rsp_carry = 0.
  - DIV, registered B ≠ 0: rsp_result = alu_op; rsp_carry = 0; rsp_err = 0.
  - DIV, registered B = 0: rsp_result = 4'h0; rsp_carry = 0; rsp_err = 1. The divide-by-zero decision uses the registered alu_b, never alu_op, so X from the unit never reaches rsp_*.
- RESP: rsp_valid = 1; rsp_* held stable until handshake. rsp_valid never drops without rsp_ready.
- After handshake, alu_* keep the last operands until the next accept. rsp_result, rsp_carry and rsp_err keep their values while rsp_valid = 0.
- cmd_* changes outside the accept edge are ignored.

## Timing
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, alu_a/alu_b 0, alu_control 00, rsp_result 0, rsp_carry 0, rsp_err 0, stat counters 0.
- Latency: accept at edge N; rsp_valid rises after edge N+SETTLE_CYCLES.
- Minimum command spacing is SETTLE_CYCLES+2 edges, with rsp_ready held high.
- rsp_ready held low stalls indefinitely in RESP; cmd_ready stays 0.
- rst_n low in any state, including mid-ISSUE or mid-RESP, immediately forces reset values. The in-flight command is discarded without a response.
- A command offered in the same cycle reset deasserts is accepted only at the first edge with rst_n high.

## Configuration
- ALU_SEQ_STATS_EN defined:
  - stat_cmds increments on every response handshake.
  - stat_errs increments on every response handshake with rsp_err = 1.
  - Both are 8-bit and saturate at 8'hFF.
- ALU_SEQ_STATS_EN undefined: the stat ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the FSM state typedef (IDLE, ISSUE, RESP);
  - the response struct (result, carry, err).
- One sub-module: alu_seq_stats, the saturating counter pair. It is instantiated only under ALU_SEQ_STATS_EN.

## Test plan
- ADD, A=9, B=8, SETTLE_CYCLES=1 -> rsp_valid one cycle after accept; result 4'h1, carry 1, err 0.
- SUB, A=3, B=5 -> result 4'hE, carry 0; SUB, A=5, B=3 -> result 4'h2, carry 1.
- DIV, A=7, B=0 with the unit driving X -> result 4'h0, carry 0, err 1, no X on rsp_*. DIV, A=9, B=2 -> result 4'h4, err 0.
- Back-to-back commands with rsp_ready low for 5 cycles -> rsp_* stable throughout, cmd_ready 0 until handshake, second command accepted the edge after IDLE is re-entered.
- rst_n pulsed low mid-ISSUE with SETTLE_CYCLES=4 -> all outputs at reset values immediately, no response emitted, next command completes normally.
- With ALU_SEQ_STATS_EN: 300 DIV-by-zero commands -> stat_cmds and stat_errs both saturate at 8'hFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, response
// record and the result-sanitising capture function.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic [3:0] result;
    logic       carry;
    logic       err;
  } alu_rsp_t;

  localparam alu_rsp_t RSP_RESET = '{result: 4'h0, carry: 1'b0, err: 1'b0};

  // Divide-by-zero is decided from the registered divisor so an X result
  // from the unit can never leak into the response.
  function automatic alu_rsp_t capture_rsp(input logic [1:0] op,
                                           input logic [3:0] b,
                                           input logic [3:0] res,
                                           input logic       c_out);
    alu_rsp_t r;
    r = RSP_RESET;
    case (op)
      OP_ADD, OP_SUB: begin
        r.result = res;
        r.carry  = c_out;
      end
      OP_MUL: r.result = res;
      OP_DIV: begin
        if (b == 4'h0) begin
          r.err = 1'b1;
        end else begin
          r.result = res;
        end
      end
      default: r = RSP_RESET;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, arithmetic-unit and response channels of the ALU command sequencer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_control;
  logic [3:0] alu_op;
  logic       alu_c_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_op, alu_c_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_control,
           rsp_valid, rsp_result, rsp_carry, rsp_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_op, alu_c_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_control,
           rsp_valid, rsp_result, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_seq_stats.sv
// Saturating 8-bit counters of completed responses and of error responses.
module alu_seq_stats (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs_i,
  input  logic       err_i,
  output logic [7:0] stat_cmds_o,
  output logic [7:0] stat_errs_o
);

  logic [7:0] cmds_q, cmds_d;
  logic [7:0] errs_q, errs_d;

  // Next-count logic, holding at 8'hFF once reached.
  always_comb begin
    cmds_d = cmds_q;
    errs_d = errs_q;
    if (hs_i) begin
      if (cmds_q != 8'hFF) begin
        cmds_d = cmds_q + 8'd1;
      end else begin
        cmds_d = cmds_q;
      end
      if (err_i && (errs_q != 8'hFF)) begin
        errs_d = errs_q + 8'd1;
      end else begin
        errs_d = errs_q;
      end
    end else begin
      cmds_d = cmds_q;
      errs_d = errs_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmds_q <= 8'h00;
      errs_q <= 8'h00;
    end else begin
      cmds_q <= cmds_d;
      errs_q <= errs_d;
    end
  end

  assign stat_cmds_o = cmds_q;
  assign stat_errs_o = errs_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registered valid/ready front-end for the 4-bit arithmetic unit.
// Optional statistics counters are built when ALU_SEQ_STATS_EN is defined.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  alu_cmd_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0] stat_cmds,
  output logic [7:0] stat_errs
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_ctl_q, alu_ctl_d;
  alu_rsp_t   rsp_q, rsp_d;

  // Next-state, operand launch, settle countdown and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_ctl_d = alu_ctl_q;
    rsp_d     = rsp_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d   = bus.cmd_a;
          alu_b_d   = bus.cmd_b;
          alu_ctl_d = bus.cmd_op;
          cnt_d     = SETTLE_LOAD;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_d   = capture_rsp(alu_ctl_q, alu_b_q, bus.alu_op, bus.alu_c_out);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      alu_a_q   <= 4'h0;
      alu_b_q   <= 4'h0;
      alu_ctl_q <= 2'b00;
      rsp_q     <= RSP_RESET;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
      rsp_q     <= rsp_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_ctl_q;
  assign bus.rsp_result  = rsp_q.result;
  assign bus.rsp_carry   = rsp_q.carry;
  assign bus.rsp_err     = rsp_q.err;

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs_i        ((state_q == RESP) && bus.rsp_ready),
    .err_i       (rsp_q.err),
    .stat_cmds_o (stat_cmds),
    .stat_errs_o (stat_errs)
  );
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench: two sequencers (settle 1 and settle 4) driving
// a behavioural arithmetic unit; stats checks build with ALU_SEQ_STATS_EN.
module tb_alu_cmd_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_cmd_sequencer_if b1 ();
  alu_cmd_sequencer_if b4 ();

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] s1_cmds, s1_errs, s4_cmds, s4_errs;
`endif

  alu_cmd_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_cmds (s1_cmds),
    .stat_errs (s1_errs)
`endif
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_cmds (s4_cmds),
    .stat_errs (s4_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unit: MUL drives carry 1 and DIV drives X carry so the bench
  // sees whether the sequencer sanitises them.
  function automatic logic [4:0] unit_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    case (op)
      2'b00:   unit_model = {1'b0, a} + {1'b0, b};
      2'b01:   unit_model = {1'b0, a} + {1'b0, ~b} + 5'd1;
      2'b10:   unit_model = {1'b1, p[3:0]};
      default: unit_model = (b == 4'h0) ? 5'bxxxxx : {1'bx, a / b};
    endcase
  endfunction

  always_comb {b1.alu_c_out, b1.alu_op} = unit_model(b1.alu_a, b1.alu_b, b1.alu_control);
  always_comb {b4.alu_c_out, b4.alu_op} = unit_model(b4.alu_a, b4.alu_b, b4.alu_control);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit sel, output logic v, output logic [3:0] r,
                        output logic c, output logic e);
    v = sel ? b4.rsp_valid  : b1.rsp_valid;
    r = sel ? b4.rsp_result : b1.rsp_result;
    c = sel ? b4.rsp_carry  : b1.rsp_carry;
    e = sel ? b4.rsp_err    : b1.rsp_err;
  endtask

  // One full command on the selected sequencer with latency and response checks.
  task automatic run(input string tag, input bit sel, input logic [3:0] a,
                     input logic [3:0] b, input logic [1:0] op, input int exp_lat,
                     input logic [3:0] er, input logic ec, input logic ee);
    logic v, c, e;
    logic [3:0] r;
    int n;
    if (sel) begin
      b4.cmd_a = a; b4.cmd_b = b; b4.cmd_op = op; b4.cmd_valid = 1'b1;
    end else begin
      b1.cmd_a = a; b1.cmd_b = b; b1.cmd_op = op; b1.cmd_valid = 1'b1;
    end
    tick();
    b1.cmd_valid = 1'b0;
    b4.cmd_valid = 1'b0;
    n = 0;
    sample(sel, v, r, c, e);
    while (!v && n < 20) begin
      tick();
      n++;
      sample(sel, v, r, c, e);
    end
    check({tag, "_lat"}, 8'(n), 8'(exp_lat));
    check({tag, "_res"}, {4'h0, r}, {4'h0, er});
    check({tag, "_carry"}, {7'h0, c}, {7'h0, ec});
    check({tag, "_err"}, {7'h0, e}, {7'h0, ee});
    b1.rsp_ready = 1'b1;
    b4.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;
    b4.rsp_ready = 1'b0;
    sample(sel, v, r, c, e);
    check({tag, "_done"}, {7'h0, v}, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    b1.cmd_valid = 1'b0; b1.cmd_a = 4'h0; b1.cmd_b = 4'h0; b1.cmd_op = 2'b00; b1.rsp_ready = 1'b0;
    b4.cmd_valid = 1'b0; b4.cmd_a = 4'h0; b4.cmd_b = 4'h0; b4.cmd_op = 2'b00; b4.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", {7'h0, b1.cmd_ready}, 8'h01);
    check("rst_rsp_valid", {7'h0, b1.rsp_valid}, 8'h00);
    check("rst_alu", {b1.alu_a, b1.alu_b}, 8'h00);
    check("rst_ctl", {6'h0, b1.alu_control}, 8'h00);
    check("rst_rsp", {2'b00, b1.rsp_result, b1.rsp_carry, b1.rsp_err}, 8'h00);
`ifdef ALU_SEQ_STATS_EN
    check("rst_stats", s1_cmds | s1_errs, 8'h00);
`endif

    // Command offered in the same cycle reset deasserts: ADD 9+8.
    rst_n = 1'b1;
    b1.cmd_a = 4'h9; b1.cmd_b = 4'h8; b1.cmd_op = 2'b00; b1.cmd_valid = 1'b1;
    tick();
    b1.cmd_valid = 1'b0;
    check("add_launch", {b1.alu_a, b1.alu_b}, 8'h98);
    check("add_issue_ready", {7'h0, b1.cmd_ready}, 8'h00);
    check("add_issue_valid", {7'h0, b1.rsp_valid}, 8'h00);
    tick();
    check("add_valid", {7'h0, b1.rsp_valid}, 8'h01);
    check("add_rsp", {2'b00, b1.rsp_result, b1.rsp_carry, b1.rsp_err}, {2'b00, 4'h1, 1'b1, 1'b0});
    b1.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;
    check("add_idle", {6'h0, b1.cmd_ready, b1.rsp_valid}, 8'h02);
    check("add_hold", {b1.rsp_result, b1.alu_a}, 8'h19);
`ifdef ALU_SEQ_STATS_EN
    check("stat_one", {s1_cmds[3:0], s1_errs[3:0]}, 8'h10);
`endif

    run("sub_neg", 1'b0, 4'h3, 4'h5, 2'b01, 1, 4'hE, 1'b0, 1'b0);
    run("sub_pos", 1'b0, 4'h5, 4'h3, 2'b01, 1, 4'h2, 1'b1, 1'b0);
    run("mul", 1'b0, 4'h7, 4'h3, 2'b10, 1, 4'h5, 1'b0, 1'b0);
    run("div0", 1'b0, 4'h7, 4'h0, 2'b11, 1, 4'h0, 1'b0, 1'b1);
    run("div", 1'b0, 4'h9, 4'h2, 2'b11, 1, 4'h4, 1'b0, 1'b0);

    // Back-to-back with a 5-cycle response stall; cmd_* changes are ignored.
    b1.cmd_a = 4'h2; b1.cmd_b = 4'h3; b1.cmd_op = 2'b00; b1.cmd_valid = 1'b1;
    tick();
    b1.cmd_a = 4'h6; b1.cmd_b = 4'h7;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp", {b1.rsp_valid, b1.cmd_ready, b1.rsp_err, b1.rsp_carry, b1.rsp_result},
            8'h85);
      check("stall_alu", {b1.alu_a, b1.alu_b}, 8'h23);
      tick();
    end
    b1.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;
    check("b2b_idle", {6'h0, b1.cmd_ready, b1.rsp_valid}, 8'h02);
    check("b2b_keep", {b1.alu_a, b1.alu_b}, 8'h23);
    tick();
    b1.cmd_valid = 1'b0;
    check("b2b_accept", {b1.alu_a, b1.alu_b}, 8'h67);
    check("b2b_busy", {7'h0, b1.cmd_ready}, 8'h00);
    tick();
    check("b2b_rsp", {b1.rsp_valid, b1.rsp_err, b1.rsp_carry, 1'b0, b1.rsp_result}, 8'h8D);
    b1.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;

    // Settle-4 sequencer: normal latency, then reset mid-ISSUE.
    run("s4_sub", 1'b1, 4'h5, 4'h3, 2'b01, 4, 4'h2, 1'b1, 1'b0);
    b4.cmd_a = 4'h1; b4.cmd_b = 4'h1; b4.cmd_op = 2'b10; b4.cmd_valid = 1'b1;
    tick();
    b4.cmd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {5'h0, b4.cmd_ready, b4.rsp_valid, b4.alu_control[1]}, 8'h04);
    check("mid_rst_alu", {b4.alu_a, b4.alu_b}, 8'h00);
    check("mid_rst_rsp", {2'b00, b4.rsp_result, b4.rsp_carry, b4.rsp_err}, 8'h00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_rsp", {6'h0, b4.rsp_valid, b4.cmd_ready}, 8'h01);
    end
    run("s4_div", 1'b1, 4'h9, 4'h2, 2'b11, 4, 4'h4, 1'b0, 1'b0);

`ifdef ALU_SEQ_STATS_EN
    for (int i = 0; i < 300; i++) begin
      b1.cmd_a = 4'h7; b1.cmd_b = 4'h0; b1.cmd_op = 2'b11; b1.cmd_valid = 1'b1;
      tick();
      b1.cmd_valid = 1'b0;
      tick();
      b1.rsp_ready = 1'b1;
      tick();
      b1.rsp_ready = 1'b0;
    end
    check("sat_cmds", s1_cmds, 8'hFF);
    check("sat_errs", s1_errs, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
